// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, multi-cycle multiply hold, memory wait freeze.
// Optional PIPE_HAZARD_PERF_EN adds free-running Stall_Cnt / Flush_Cnt event counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_MulStart,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_Taken,
  input  logic        Mem_Wait,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        IFID_Flush,
  output logic        IDEX_EN,
  output logic        IDEX_Flush,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt,
`endif
  output logic        Stall
);

  typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_t;

  // A single-cycle multiply never holds the front end, so the start is ignored.
  localparam logic             MUL_EN   = 1'(MUL_LAT >= 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic rs_hit, rt_hit, loaduse, mul_busy, mulstall;

  assign rs_hit   = ID_UseRs && (ID_Rs == EX_Rt);
  assign rt_hit   = ID_UseRt && (ID_Rt == EX_Rt);
  assign loaduse  = EX_MemRead && (EX_Rt != 5'd0) && (rs_hit || rt_hit);
  assign mul_busy = (state == MUL) && (cnt != '0);
  assign mulstall = ((state == RUN) && ID_MulStart && MUL_EN && !loaduse) || mul_busy;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (Mem_Wait) begin
      // Frozen pipeline still lets the multiplier run; the state stays put.
      cnt_nxt = (cnt != '0) ? (cnt - CNT_W'(1)) : '0;
    end else if (EX_Taken) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (!loaduse) begin
      if (mulstall) begin
        if (state == RUN) begin
          state_nxt = MUL;
          cnt_nxt   = CNT_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end else if (state == MUL) begin
        state_nxt = RUN;
      end
    end
  end

  always_comb begin
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_EN    = 1'b1;
    IDEX_Flush = 1'b0;
    Stall      = 1'b0;
    if (!Clrn) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_EN    = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (Mem_Wait) begin
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
      IDEX_EN = 1'b0;
      Stall   = 1'b1;
    end else if (EX_Taken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (loaduse || mulstall) begin
      // Hold IF/ID and PC, push one bubble into ID/EX.
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_Flush = 1'b1;
      Stall      = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic flush_evt;
  assign flush_evt = EX_Taken && !Mem_Wait;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (Stall)     Stall_Cnt <= Stall_Cnt + 32'd1;
      if (flush_evt) Flush_Cnt <= Flush_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MUL_LAT=4); perf counter checks compile in with PIPE_HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UseRs, ID_UseRt, ID_MulStart, EX_MemRead, EX_Taken, Mem_Wait;
  logic       PC_EN, IFID_EN, IFID_Flush, IDEX_EN, IDEX_Flush, Stall;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] Stall_Cnt, Flush_Cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {PC_EN, IFID_EN, IFID_Flush, IDEX_EN, IDEX_Flush, Stall}
  localparam logic [5:0] NORM   = 6'b110100;
  localparam logic [5:0] STL    = 6'b000111;
  localparam logic [5:0] FLUSH  = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000001;
  localparam logic [5:0] RSTV   = 6'b001010;

  logic [5:0] outs;
  assign outs = {PC_EN, IFID_EN, IFID_Flush, IDEX_EN, IDEX_Flush, Stall};

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_MulStart(ID_MulStart), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_Taken(EX_Taken), .Mem_Wait(Mem_Wait),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_Flush(IFID_Flush),
    .IDEX_EN(IDEX_EN), .IDEX_Flush(IDEX_Flush),
`ifdef PIPE_HAZARD_PERF_EN
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt),
`endif
    .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  // Stimulus word: {Mem_Wait, EX_Taken, ID_MulStart, EX_MemRead, EX_Rt, ID_UseRs, ID_Rs, ID_UseRt, ID_Rt}
  function automatic logic [20:0] mk(input logic mw, input logic tk, input logic mul, input logic mr,
                                     input logic [4:0] exrt, input logic urs, input logic [4:0] rs,
                                     input logic urt, input logic [4:0] rt);
    return {mw, tk, mul, mr, exrt, urs, rs, urt, rt};
  endfunction

  task automatic apply(input logic [20:0] v);
    {Mem_Wait, EX_Taken, ID_MulStart, EX_MemRead, EX_Rt, ID_UseRs, ID_Rs, ID_UseRt, ID_Rt} = v;
  endtask

  task automatic test_reset;
    Clrn = 1'b0;
    apply(mk(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0));
    #2;
    checks++;
    if (outs !== RSTV) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", outs, RSTV);
    end
    @(negedge Clk);
    apply(mk(0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0));
    #1;
    checks++;
    if (outs !== RSTV) begin
      errors++;
      $display("FAIL reset_inputs_masked: got %b expected %b", outs, RSTV);
    end
    @(negedge Clk);
    Clrn = 1'b1;
    apply('0);
    #1;
    checks++;
    if (outs !== NORM) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", outs, NORM);
    end
  endtask

  task automatic test_loaduse;
    logic [20:0] stim [6];
    logic [5:0]  exp [6];
    stim[0] = mk(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0); exp[0] = STL;
    stim[1] = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[1] = NORM;
    stim[2] = mk(0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0); exp[2] = NORM;
    stim[3] = mk(0, 0, 0, 1, 5'd7, 0, 5'd7, 1, 5'd7); exp[3] = STL;
    stim[4] = mk(0, 0, 0, 1, 5'd9, 0, 5'd9, 0, 5'd3); exp[4] = NORM;
    stim[5] = mk(0, 0, 0, 0, 5'd5, 1, 5'd5, 0, 5'd0); exp[5] = NORM;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      apply(stim[i]);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL loaduse[%0d]: got %b expected %b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic [20:0] stim [10];
    logic [5:0]  exp [10];
    // Plain multiply: three stalls, release with MulStart still high, then idle.
    stim[0] = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[0] = STL;
    stim[1] = stim[0];                                exp[1] = STL;
    stim[2] = stim[0];                                exp[2] = STL;
    stim[3] = stim[0];                                exp[3] = NORM;
    stim[4] = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[4] = NORM;
    // Load-use beats a multiply start: one bubble, then the full multiply.
    stim[5] = mk(0, 0, 1, 1, 5'd4, 1, 5'd4, 0, 5'd0); exp[5] = STL;
    stim[6] = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[6] = STL;
    stim[7] = stim[6];                                exp[7] = STL;
    stim[8] = stim[6];                                exp[8] = STL;
    stim[9] = stim[6];                                exp[9] = NORM;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      apply(stim[i]);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL mul[%0d]: got %b expected %b", i, outs, exp[i]);
      end
    end
    @(negedge Clk);
    apply('0);
  endtask

  task automatic test_branch;
    logic [20:0] stim [7];
    logic [5:0]  exp [7];
    stim[0] = mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[0] = FLUSH;
    stim[1] = mk(0, 1, 0, 1, 5'd6, 1, 5'd6, 0, 5'd0); exp[1] = FLUSH;
    // Taken branch on the second stall cycle cancels the multiply.
    stim[2] = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[2] = STL;
    stim[3] = mk(0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[3] = FLUSH;
    stim[4] = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[4] = NORM;
    stim[5] = stim[4];                                exp[5] = NORM;
    stim[6] = stim[4];                                exp[6] = NORM;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      apply(stim[i]);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL branch[%0d]: got %b expected %b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_mem_wait;
    logic [20:0] stim [10];
    logic [5:0]  exp [10];
    stim[0] = mk(1, 1, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0); exp[0] = FREEZE;
    stim[1] = stim[0];                                exp[1] = FREEZE;
    stim[2] = mk(0, 1, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0); exp[2] = FLUSH;
    stim[3] = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[3] = NORM;
    // Wait during a multiply keeps counting down and holds MUL at zero.
    stim[4] = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[4] = STL;
    stim[5] = mk(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); exp[5] = FREEZE;
    stim[6] = stim[5];                                exp[6] = FREEZE;
    stim[7] = stim[5];                                exp[7] = FREEZE;
    stim[8] = stim[4];                                exp[8] = NORM;
    stim[9] = stim[3];                                exp[9] = NORM;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      apply(stim[i]);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    @(negedge Clk);
    apply(mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0));
    @(negedge Clk);
    #1;
    checks++;
    if (outs !== STL) begin
      errors++;
      $display("FAIL mid_mul_stall: got %b expected %b", outs, STL);
    end
    #1;
    Clrn = 1'b0;
    #1;
    checks++;
    if (outs !== RSTV) begin
      errors++;
      $display("FAIL mid_mul_async_reset: got %b expected %b", outs, RSTV);
    end
    @(negedge Clk);
    Clrn = 1'b1;
    apply('0);
    #1;
    checks++;
    if (outs !== NORM) begin
      errors++;
      $display("FAIL mid_mul_after_release: got %b expected %b", outs, NORM);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (outs !== NORM) begin
      errors++;
      $display("FAIL mid_mul_still_run: got %b expected %b", outs, NORM);
    end
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf;
    logic [20:0] stim [8];
    @(negedge Clk);
    Clrn = 1'b0;
    apply('0);
    @(negedge Clk);
    Clrn = 1'b1;
    stim[0] = mk(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    stim[1] = '0;
    stim[2] = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    stim[3] = stim[2];
    stim[4] = stim[2];
    stim[5] = stim[2];
    stim[6] = mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    stim[7] = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      apply(stim[i]);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (Stall_Cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_stall_cnt: got %0d expected 4", Stall_Cnt);
    end
    checks++;
    if (Flush_Cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_flush_cnt: got %0d expected 1", Flush_Cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loaduse();
    test_mul();
    test_branch();
    test_mem_wait();
    test_reset_mid_mul();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
